mem_arbiter: RTL and testbench

Sequencer and arbiter for the single-port main memory shared by the control unit's instruction-fetch path and its data path (lw/sw/push/pop). It accepts one request at a time from each of two requesters, grants one, and drives the memory READ/WRITE/address/data pins for a fixed access latency. It returns read data with a one-cycle acknowledge. It sits between the control unit/datapath and the memory model and replaces direct CTRL-driven memory strobes.

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_arb_timer.sv | 32 +++
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants, state encoding and the fetch/data arbitration rule for the
// main-memory arbiter.
package mem_arbiter_pkg;

  localparam int ARB_ADDR_W     = 26;
  localparam int ARB_DATA_W     = 32;
  localparam int DEF_MEM_LAT    = 2;
  localparam int DEF_STARVE_MAX = 4;
  localparam int TMR_W          = 4;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_ACK    = 2'd2
  } arb_state_e;

  // Data normally wins; a starved fetch overrides it.
  function automatic logic arb_fetch_wins(input logic i_req, input logic d_req,
                                          input logic starved);
    return i_req & (~d_req | starved);
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Loadable down-counter with zero flag, used to time the memory strobe window.
module mem_arb_timer
  import mem_arbiter_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_r;

  // Count register: load wins over decrement, holds at zero.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != {W{1'b0}})) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {W{1'b0}});

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) sequencer for the single-port main memory:
// arbitrates, holds the strobe for MEM_LAT cycles, then pulses the winner's ACK.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ARB_ADDR_W,
  parameter int DATA_W     = ARB_DATA_W,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              I_REQ,
  input  logic [ADDR_W-1:0] I_ADDR,
  output logic              I_ACK,
  output logic [DATA_W-1:0] I_DATA,
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic [DATA_W-1:0] D_WDATA,
  output logic              D_ACK,
  output logic [DATA_W-1:0] D_RDATA,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              BUSY
);

  localparam int                SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]     STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [TMR_W-1:0]  LAT_LOAD   = TMR_W'(MEM_LAT - 1);

  arb_state_e    state_r;
  logic [SW-1:0] starve_r;
  logic          we_r;
  logic          fetch_r;
  logic          grant_fetch_s;
  logic          load_s;
  logic          dec_s;
  logic          tmr_zero_s;

  // Grant decision and timer control, evaluated against the current requests.
  always_comb begin
    grant_fetch_s = arb_fetch_wins(I_REQ, D_REQ, starve_r == STARVE_LIM);
    load_s        = (state_r == ARB_IDLE) && (I_REQ || D_REQ);
    dec_s         = (state_r == ARB_ACCESS);
  end

  mem_arb_timer #(.W(TMR_W)) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .load     (load_s),
    .load_val (LAT_LOAD),
    .dec      (dec_s),
    .zero     (tmr_zero_s)
  );

  // Sequencer FSM with registered memory strobes, acknowledges and read data.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r   <= ARB_IDLE;
      starve_r  <= {SW{1'b0}};
      we_r      <= 1'b0;
      fetch_r   <= 1'b0;
      I_ACK     <= 1'b0;
      D_ACK     <= 1'b0;
      MEM_READ  <= 1'b0;
      MEM_WRITE <= 1'b0;
      BUSY      <= 1'b0;
      MEM_ADDR  <= {ADDR_W{1'b0}};
      MEM_WDATA <= {DATA_W{1'b0}};
      I_DATA    <= {DATA_W{1'b0}};
      D_RDATA   <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        ARB_IDLE: begin
          I_ACK <= 1'b0;
          D_ACK <= 1'b0;
          if (I_REQ || D_REQ) begin
            state_r   <= ARB_ACCESS;
            BUSY      <= 1'b1;
            fetch_r   <= grant_fetch_s;
            we_r      <= ~grant_fetch_s & D_WE;
            MEM_READ  <= grant_fetch_s | ~D_WE;
            MEM_WRITE <= ~grant_fetch_s & D_WE;
            MEM_ADDR  <= grant_fetch_s ? I_ADDR : D_ADDR;
            MEM_WDATA <= grant_fetch_s ? {DATA_W{1'b0}} : D_WDATA;
            // Only data grants made while fetch is waiting count toward starvation.
            if (grant_fetch_s || !I_REQ) begin
              starve_r <= {SW{1'b0}};
            end else if (starve_r != STARVE_LIM) begin
              starve_r <= starve_r + SW'(1);
            end else begin
              starve_r <= starve_r;
            end
          end else begin
            state_r <= ARB_IDLE;
          end
        end
        ARB_ACCESS: begin
          if (tmr_zero_s) begin
            state_r   <= ARB_ACK;
            MEM_READ  <= 1'b0;
            MEM_WRITE <= 1'b0;
            I_ACK     <= fetch_r;
            D_ACK     <= ~fetch_r;
            if (!we_r && fetch_r) begin
              I_DATA <= MEM_RDATA;
            end else if (!we_r) begin
              D_RDATA <= MEM_RDATA;
            end else begin
              D_RDATA <= D_RDATA;
            end
          end else begin
            state_r <= ARB_ACCESS;
          end
        end
        ARB_ACK: begin
          state_r <= ARB_IDLE;
          I_ACK   <= 1'b0;
          D_ACK   <= 1'b0;
          BUSY    <= 1'b0;
        end
        default: begin
          state_r   <= ARB_IDLE;
          I_ACK     <= 1'b0;
          D_ACK     <= 1'b0;
          MEM_READ  <= 1'b0;
          MEM_WRITE <= 1'b0;
          BUSY      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter at MEM_LAT = 2, 1 and 15.
module tb_mem_arbiter;

  localparam int STARVE = 4;
  localparam int TMO    = 400;

  typedef struct {
    bit          fetch;
    bit          we;
    logic [25:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_edge;
  } exp_t;

  logic CLK = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  logic [25:0] addr_tab [8] = '{26'h0000000, 26'h0000001, 26'h0000010, 26'h3FFFFFF,
                                26'h2AAAAAA, 26'h0000155, 26'h0000007, 26'h0000100};

  initial forever #5 CLK = ~CLK;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  function automatic logic [25:0] rand_addr();
    return addr_tab[$urandom_range(0, 7)];
  endfunction

  // Initial memory contents: 0x10 reads as 0x20010002.
  function automatic logic [31:0] init_val(logic [25:0] a);
    return 32'h2001_0000 ^ 32'(a >> 3);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 15);

    logic        RST, I_REQ, I_ACK, D_REQ, D_WE, D_ACK, MEM_READ, MEM_WRITE, BUSY;
    logic [25:0] I_ADDR, D_ADDR, MEM_ADDR;
    logic [31:0] I_DATA, D_WDATA, D_RDATA, MEM_WDATA, MEM_RDATA;

    mem_arbiter #(.ADDR_W(26), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(STARVE)) dut (
      .CLK(CLK), .RST(RST),
      .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_ACK(I_ACK), .I_DATA(I_DATA),
      .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
      .D_ACK(D_ACK), .D_RDATA(D_RDATA),
      .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDR(MEM_ADDR),
      .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .BUSY(BUSY)
    );

    // Memory device: data valid only in the LAT-th consecutive read strobe cycle.
    logic [31:0] dev_mem [bit [25:0]];
    int rd_cnt = 0;
    initial MEM_RDATA = 32'hBAD0_0BAD;
    always @(negedge CLK) begin
      rd_cnt = (RST && MEM_READ) ? rd_cnt + 1 : 0;
      if (RST && MEM_WRITE) dev_mem[MEM_ADDR] = MEM_WDATA;
      if (MEM_READ && rd_cnt == LAT)
        MEM_RDATA = dev_mem.exists(MEM_ADDR) ? dev_mem[MEM_ADDR] : init_val(MEM_ADDR);
      else
        MEM_RDATA = 32'hBAD0_0BAD ^ 32'(rd_cnt);
    end

    // Reference model: grant times from arithmetic, winner from the priority rule.
    logic [31:0] ref_mem [bit [25:0]];
    exp_t        q [$];
    int          cyc = 0, free_at = 0, starve = 0, g_edge = -100;
    bit          g_we;
    logic [25:0] g_addr;
    logic [31:0] g_wdata;
    always @(posedge CLK) begin
      exp_t e;
      bit   fw;
      cyc++;
      if (!RST) begin
        free_at = 0; starve = 0; g_edge = -100;
      end else if (cyc >= free_at && (I_REQ || D_REQ)) begin
        fw = I_REQ && (!D_REQ || starve == STARVE);
        e.fetch = fw;
        e.we    = fw ? 1'b0 : D_WE;
        e.addr  = fw ? I_ADDR : D_ADDR;
        e.wdata = D_WDATA;
        starve  = fw ? 0 : (I_REQ ? ((starve < STARVE) ? starve + 1 : STARVE) : 0);
        e.rdata = e.we ? 32'h0 :
                  (ref_mem.exists(e.addr) ? ref_mem[e.addr] : init_val(e.addr));
        if (e.we) ref_mem[e.addr] = e.wdata;
        e.ack_edge = cyc + LAT;
        free_at = cyc + LAT + 2;
        g_edge = cyc; g_we = e.we; g_addr = e.addr; g_wdata = e.wdata;
        q.push_back(e);
      end
    end

    // Monitor: strobe window, BUSY, ACK pops and held read data, 1 ns after the edge.
    logic [31:0] exp_i = 32'h0, exp_d = 32'h0;
    always @(posedge CLK) begin
      exp_t e;
      bit   in_str, in_busy;
      #1;
      if (!RST) begin
        q.delete();
        exp_i = 32'h0; exp_d = 32'h0;
        chk($sformatf("L%0d rst_strobes", LAT), {62'h0, MEM_READ, MEM_WRITE}, 64'h0);
      end else begin
        in_str  = (cyc >= g_edge) && (cyc <= g_edge + LAT - 1);
        in_busy = (cyc >= g_edge) && (cyc <= g_edge + LAT);
        chk($sformatf("L%0d mem_read@%0d", LAT, cyc), 64'(MEM_READ), 64'(in_str && !g_we));
        chk($sformatf("L%0d mem_write@%0d", LAT, cyc), 64'(MEM_WRITE), 64'(in_str && g_we));
        chk($sformatf("L%0d busy@%0d", LAT, cyc), 64'(BUSY), 64'(in_busy));
        if (in_str) chk($sformatf("L%0d mem_addr", LAT), 64'(MEM_ADDR), 64'(g_addr));
        if (in_str && g_we) chk($sformatf("L%0d mem_wdata", LAT), 64'(MEM_WDATA), 64'(g_wdata));
        if (I_ACK || D_ACK) begin
          if (q.size() == 0) begin
            chk($sformatf("L%0d spurious_ack@%0d", LAT, cyc), 64'({I_ACK, D_ACK}), 64'h0);
          end else begin
            e = q.pop_front();
            chk($sformatf("L%0d ack_who", LAT), 64'({I_ACK, D_ACK}), 64'({e.fetch, !e.fetch}));
            chk($sformatf("L%0d ack_edge", LAT), 64'(cyc), 64'(e.ack_edge));
            if (e.fetch) exp_i = e.rdata;
            else if (!e.we) exp_d = e.rdata;
          end
        end else if (q.size() > 0 && cyc > q[0].ack_edge) begin
          e = q.pop_front();
          chk($sformatf("L%0d missing_ack", LAT), 64'(cyc), 64'(e.ack_edge));
        end
        chk($sformatf("L%0d i_data", LAT), 64'(I_DATA), 64'(exp_i));
        chk($sformatf("L%0d d_rdata", LAT), 64'(D_RDATA), 64'(exp_d));
      end
    end

    // Fetch requester: a directed fetch of 0x10, then random addresses.
    initial begin
      int t;
      I_REQ = 1'b0; I_ADDR = 26'h0;
      repeat (3) @(negedge CLK);
      for (int n = 0; n < 15; n++) begin
        int gap = (n == 0) ? 0 : $urandom_range(0, 4);
        for (int k = 0; k < gap; k++) begin I_REQ = 1'b0; @(negedge CLK); end
        I_REQ = 1'b1;
        I_ADDR = (n == 0) ? 26'h0000010 : rand_addr();
        t = 0;
        do begin
          @(negedge CLK); t++;
          if (!I_ACK && n > 0) I_ADDR = rand_addr();
        end while (!I_ACK && t < TMO);
        if (t >= TMO) chk($sformatf("L%0d i_timeout", LAT), 64'(t), 64'(TMO - 1));
      end
      I_REQ = 1'b0;
      done_cnt++;
    end

    // Data requester: write 0x3FFFFFF, read it back, then random traffic biased to back-to-back.
    initial begin
      int t;
      D_REQ = 1'b0; D_WE = 1'b0; D_ADDR = 26'h0; D_WDATA = 32'h0;
      repeat (3) @(negedge CLK);
      for (int n = 0; n < 40; n++) begin
        int gap = (n < 2 || $urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, 3);
        for (int k = 0; k < gap; k++) begin D_REQ = 1'b0; @(negedge CLK); end
        D_REQ   = 1'b1;
        D_WE    = (n == 0) ? 1'b1 : ((n == 1) ? 1'b0 : 1'($urandom_range(0, 1)));
        D_ADDR  = (n < 2) ? 26'h3FFFFFF : rand_addr();
        D_WDATA = (n == 0) ? 32'hDEADBEEF : $urandom;
        t = 0;
        do begin
          @(negedge CLK); t++;
          if (!D_ACK && n > 1) begin D_ADDR = rand_addr(); D_WDATA = $urandom; end
        end while (!D_ACK && t < TMO);
        if (t >= TMO) chk($sformatf("L%0d d_timeout", LAT), 64'(t), 64'(TMO - 1));
      end
      D_REQ = 1'b0;
      done_cnt++;
    end

    // Reset control: power-on reset values, then an asynchronous reset during a read strobe.
    initial begin
      int t;
      RST = 1'b0;
      #12;
      chk($sformatf("L%0d por_outs", LAT),
          64'({I_ACK, D_ACK, MEM_READ, MEM_WRITE, BUSY}), 64'h0);
      chk($sformatf("L%0d por_data", LAT), {I_DATA, D_RDATA}, 64'h0);
      chk($sformatf("L%0d por_mem", LAT), {6'h0, MEM_ADDR, MEM_WDATA}, 64'h0);
      @(negedge CLK);
      RST = 1'b1;
      repeat (60) @(negedge CLK);
      t = 0;
      while (!MEM_READ && t < 500) begin @(negedge CLK); t++; end
      if (t >= 500) chk($sformatf("L%0d rst_wait", LAT), 64'(t), 64'h0);
      #1 RST = 1'b0;
      #1;
      chk($sformatf("L%0d async_rst_outs", LAT),
          64'({I_ACK, D_ACK, MEM_READ, MEM_WRITE, BUSY}), 64'h0);
      chk($sformatf("L%0d async_rst_data", LAT), {I_DATA, D_RDATA}, 64'h0);
      chk($sformatf("L%0d async_rst_addr", LAT), 64'(MEM_ADDR), 64'h0);
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      done_cnt++;
    end
  end

  initial begin
    int t = 0;
    while (done_cnt < 9 && t < 20000) begin @(negedge CLK); t++; end
    if (done_cnt < 9) chk("global_timeout", 64'(done_cnt), 64'd9);
    repeat (20) @(negedge CLK);
    chk("l2_queue_drained", 64'(u[0].q.size()), 64'h0);
    chk("l1_queue_drained", 64'(u[1].q.size()), 64'h0);
    chk("l15_queue_drained", 64'(u[2].q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
